// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch stage: queue entry layout, FSM states
// and the word-alignment helper.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN_DEFAULT-1:0] align_word(input logic [XLEN_DEFAULT-1:0] a);
    return {a[XLEN_DEFAULT-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the memory request/response, redirect and decode handshakes of fetch_queue.
// master = the fetch stage, slave = its environment (memory, branch unit, decode).
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_instr;
  logic [CW-1:0]   count;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with synchronous clear.
// Clear wins over push/pop; push is accepted when full only alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  entry_t                     i_entry,
  input  logic                       i_pop,
  output entry_t                     o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_pop;
  logic            w_push;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only: no reset, written only when the entry is really accepted.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_tail] <= i_entry;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: sequential fetch, credit-limited issue, FIFO to decode,
// redirect flush. Optional combinational bypass when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_take;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_rsp_entry;

  // Words already queued plus the one due back from memory must fit in the queue.
  assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      BOOT:  w_state_nxt = RUN;
      RUN: begin
        if (bus.redirect_valid) w_state_nxt = r_inflight ? FLUSH : RUN;
        else                    w_req_valid = (w_credit < LP_DEPTH);
      end
      FLUSH: w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  assign w_req_fire  = w_req_valid & bus.imem_req_ready;
  assign w_rsp_take  = (r_state == RUN) & r_inflight & bus.imem_rsp_valid & ~bus.redirect_valid;
  assign w_rsp_entry = '{pc: r_inflight_pc, instr: bus.imem_rsp_data};
  assign w_pop       = ~w_empty & bus.dec_ready & ~bus.redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = w_rsp_take & (w_count == '0);
  assign w_push        = w_rsp_take & ~(w_bypass & bus.dec_ready);
  assign bus.dec_valid = ~w_empty | w_bypass;
  assign bus.dec_pc    = w_bypass ? w_rsp_entry.pc    : w_head.pc;
  assign bus.dec_instr = w_bypass ? w_rsp_entry.instr : w_head.instr;
`else
  assign w_push        = w_rsp_take;
  assign bus.dec_valid = ~w_empty;
  assign bus.dec_pc    = w_head.pc;
  assign bus.dec_instr = w_head.instr;
`endif

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.count          = w_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req_fire;
      if (bus.redirect_valid) r_fetch_pc <= align_word(bus.redirect_pc);
      else if (w_req_fire)    r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_inflight_pc <= r_fetch_pc;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (bus.redirect_valid),
    .i_push  (w_push),
    .i_entry (w_rsp_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: one-cycle memory model, expected-PC scoreboard filled on each
// accepted request and drained on each decode handshake.
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst_n;

  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          first_req;
  int          first_dec;
  int          pops;
  int          max_cnt;
  logic        last_fire;
  logic        seen_wrap;
  logic        arm_first;
  logic        found;
  logic [31:0] first_pc_after;
  logic [31:0] exp_req_pc;
  logic [31:0] prev_addr;
  logic [31:0] exp_q[$];

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: observe at negedge, then drive the memory response just after posedge.
  task automatic step();
    logic        fire;
    logic [31:0] faddr;
    logic [31:0] e;
    @(negedge clk);
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    fire  = bus.imem_req_valid & bus.imem_req_ready;
    faddr = bus.imem_req_addr;
    if (fire) begin
      chk_eq("req_addr", faddr, exp_req_pc);
      exp_q.push_back(exp_req_pc);
      if (prev_addr == 32'hFFFF_FFFC && faddr == 32'h0) seen_wrap = 1'b1;
      prev_addr = faddr;
      if (first_req < 0) first_req = cyc;
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (bus.dec_valid && first_dec < 0) first_dec = cyc;
    if (bus.redirect_valid) begin
      chk_eq("req_in_rdr", bus.imem_req_valid, 0);
      exp_q.delete();
      exp_req_pc = {bus.redirect_pc[31:2], 2'b00};
      arm_first  = 1'b1;
    end else if (bus.dec_valid && bus.dec_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk_eq("sb_underflow", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk_eq("dec_pc", bus.dec_pc, e);
        chk_eq("dec_instr", bus.dec_instr, mem_word(e));
        if (arm_first) begin
          first_pc_after = bus.dec_pc;
          arm_first      = 1'b0;
        end
      end
    end
    last_fire = fire;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = fire;
    bus.imem_rsp_data  = fire ? mem_word(faddr) : 32'h0;
    cyc++;
  endtask

  task automatic restart_model();
    cyc        = 0;
    first_req  = -1;
    first_dec  = -1;
    pops       = 0;
    exp_req_pc = 32'h0;
    exp_q.delete();
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b1;
    max_cnt            = 0;
    last_fire          = 1'b0;
    seen_wrap          = 1'b0;
    arm_first          = 1'b0;
    found              = 1'b0;
    first_pc_after     = 32'h0;
    prev_addr          = 32'h0;
    restart_model();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_dec_valid", bus.dec_valid, 0);
    chk_eq("rst_req_valid", bus.imem_req_valid, 0);
    chk_eq("rst_count", bus.count, 0);
    chk_eq("rst_addr", bus.imem_req_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming with decode always ready.
    repeat (12) step();
    chk_eq("boot_req_cyc", first_req, 1);
    chk_eq("first_latency", first_dec - first_req, LAT);
    chk_eq("throughput", pops, 11 - LAT);

    // Decode stall: queue fills, requests stop, then drains in order.
    bus.dec_ready = 1'b0;
    repeat (10) step();
    chk_eq("stall_count", bus.count, DEPTH);
    chk_eq("stall_req_valid", bus.imem_req_valid, 0);
    chk_eq("max_count", max_cnt, DEPTH);
    bus.dec_ready = 1'b1;
    repeat (10) step();

    // Redirect with count=3 and a word in flight.
    bus.dec_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.count == 3'd3 && last_fire) found = 1'b1;
    end
    chk_eq("c3_reached", found, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    step();
    bus.redirect_valid = 1'b0;
    chk_eq("rdr_count", bus.count, 0);
    chk_eq("rdr_dec_valid", bus.dec_valid, 0);
    bus.dec_ready = 1'b1;
    repeat (8) step();
    chk_eq("rdr_first_pc", first_pc_after, 32'h100);

    // Redirect coincident with a pop and a push.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    bus.redirect_valid = 1'b0;
    chk_eq("rdr2_count", bus.count, 0);
    chk_eq("rdr2_dec_valid", bus.dec_valid, 0);
    repeat (8) step();
    chk_eq("rdr2_first_pc", first_pc_after, 32'h200);

    // Address wrap past the top of memory.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    repeat (8) step();
    chk_eq("wrap", seen_wrap, 1);
    chk_eq("wrap_first_pc", first_pc_after, 32'hFFFF_FFF8);

    // Asynchronous reset with a request in flight.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (last_fire) found = 1'b1;
    end
    chk_eq("inflight_reached", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_dec_valid", bus.dec_valid, 0);
    chk_eq("arst_req_valid", bus.imem_req_valid, 0);
    chk_eq("arst_count", bus.count, 0);
    chk_eq("arst_addr", bus.imem_req_addr, 32'h0);
    restart_model();
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) step();
    chk_eq("rerun_req_cyc", first_req, 1);
    chk_eq("rerun_latency", first_dec - first_req, LAT);
    chk_eq("rerun_pops", pops, 11 - LAT);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
